// File: rtl/write_pix.sv
// Write-side ZBT bank-1 packer: pairs even/odd pixels into 36-bit words, buffers them
// in a small FIFO and issues writes only in granted bus slots, data lagging by the ZBT pipe.
module write_pix #(
    parameter int FIFO_DEPTH     = 4,
    parameter int ZBT_DATA_DELAY = 2,
    parameter int H_ACTIVE       = 1024,
    parameter int V_ACTIVE       = 768
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_pix_valid,
    input  logic [17:0]                   i_pix_data,
    input  logic [10:0]                   i_pix_hcount,
    input  logic [9:0]                    i_pix_vcount,
    input  logic                          i_wr_slot,
    output logic [18:0]                   o_vram_addr,
    output logic                          o_vram_we,
    output logic [35:0]                   o_vram_write_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow,
    output logic                          o_pair_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int D  = ZBT_DATA_DELAY;
    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

    typedef enum logic {EMPTY, HALF} state_t;

    state_t      r_state, w_state_nxt;
    logic [17:0] r_lat_data;
    logic [10:0] r_lat_h;
    logic [9:0]  r_lat_v;

    logic w_take, w_latch, w_push, w_err;

    logic [54:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          w_pop, w_full, w_push_ok;
    logic [54:0]   w_head;

    logic [D-1:0]  r_dvld;
    logic [35:0]   r_ddat [D];
    logic [18:0]   r_vram_addr;
    logic          r_vram_we;
    logic [35:0]   r_vram_write_data;
    logic          r_overflow, r_pair_err;

    assign w_take = i_pix_valid && (i_pix_hcount < H_LIM) && (i_pix_vcount < V_LIM);

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_push      = 1'b0;
        w_err       = 1'b0;
        if (w_take) begin
            case (r_state)
                EMPTY: begin
                    if (!i_pix_hcount[0]) begin
                        w_latch     = 1'b1;
                        w_state_nxt = HALF;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                HALF: begin
                    if (!i_pix_hcount[0]) begin
                        // A fresh even pixel supersedes the orphaned one.
                        w_latch = 1'b1;
                        w_err   = 1'b1;
                    end else if (i_pix_hcount == r_lat_h + 11'd1 && i_pix_vcount == r_lat_v) begin
                        w_push      = 1'b1;
                        w_state_nxt = EMPTY;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = EMPTY;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= EMPTY;
            r_lat_data <= '0;
            r_lat_h    <= '0;
            r_lat_v    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_lat_data <= i_pix_data;
                r_lat_h    <= i_pix_hcount;
                r_lat_v    <= i_pix_vcount;
            end
        end
    end

    // A pop frees the slot in the same cycle, so push+pop on a full FIFO is legal.
    assign w_pop     = i_wr_slot && (r_count != '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_head    = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wptr] <= {i_pix_vcount, i_pix_hcount[9:1], r_lat_data, i_pix_data};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_pair_err <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PW'(1);
            if (w_pop)     r_rptr <= r_rptr + PW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
            if (w_err)                r_pair_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vram_we         <= 1'b0;
            r_vram_addr       <= '0;
            r_vram_write_data <= '0;
            r_dvld            <= '0;
            for (int k = 0; k < D; k++) r_ddat[k] <= '0;
        end else begin
            r_vram_we <= w_pop;
            if (w_pop) r_vram_addr <= w_head[54:36];
            r_dvld[0] <= w_pop;
            r_ddat[0] <= w_head[35:0];
            for (int k = 1; k < D; k++) begin
                r_dvld[k] <= r_dvld[k-1];
                r_ddat[k] <= r_ddat[k-1];
            end
            if (r_dvld[D-1]) r_vram_write_data <= r_ddat[D-1];
        end
    end

    assign o_vram_addr       = r_vram_addr;
    assign o_vram_we         = r_vram_we;
    assign o_vram_write_data = r_vram_write_data;
    assign o_fifo_count      = r_count;
    assign o_overflow        = r_overflow;
    assign o_pair_err        = r_pair_err;

endmodule

// File: tb/tb_write_pix.sv
// Bench for write_pix: directed pixel streams; expected ZBT writes are queued by the
// stimulus and checked by an independent bus monitor, plus directed flag/count checks.
module tb_write_pix;

    localparam int D = 2;

    logic        clk, reset, pix_valid, wr_slot;
    logic [17:0] pix_data;
    logic [10:0] pix_hcount;
    logic [9:0]  pix_vcount;
    logic [18:0] vram_addr;
    logic        vram_we;
    logic [35:0] vram_write_data;
    logic [2:0]  fifo_count;
    logic        overflow, pair_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [54:0] exp_q[$];
    logic [35:0] dat_q[$];
    int          due_q[$];

    write_pix dut (
        .i_clk(clk), .i_reset(reset), .i_pix_valid(pix_valid), .i_pix_data(pix_data),
        .i_pix_hcount(pix_hcount), .i_pix_vcount(pix_vcount), .i_wr_slot(wr_slot),
        .o_vram_addr(vram_addr), .o_vram_we(vram_we), .o_vram_write_data(vram_write_data),
        .o_fifo_count(fifo_count), .o_overflow(overflow), .o_pair_err(pair_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; the pixel is presented for exactly one cycle.
    task automatic pix(input int h, input int v, input logic [17:0] d);
        pix_valid  = 1'b1;
        pix_hcount = 11'(h);
        pix_vcount = 10'(v);
        pix_data   = d;
        @(negedge clk);
        pix_valid  = 1'b0;
    endtask

    task automatic expect_word(input int v, input int h_even, input logic [17:0] de, input logic [17:0] dodd);
        logic [10:0] hh;
        hh = 11'(h_even);
        exp_q.push_back({10'(v), hh[9:1], de, dodd});
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (exp_q.size() != 0 || dat_q.size() != 0); i++) @(negedge clk);
        chk("drain_pending", 64'(exp_q.size() + dat_q.size()), 64'd0);
        chk("drain_count", 64'(fifo_count), 64'd0);
    endtask

    task automatic fill4(input int v, input int base);
        for (int k = 0; k < 4; k++) begin
            pix(2*k, v, 18'(base + 2*k));
            expect_word(v, 2*k, 18'(base + 2*k), 18'(base + 2*k + 1));
            pix(2*k + 1, v, 18'(base + 2*k + 1));
        end
    endtask

    // Bus monitor: every write must match the queue head, data D cycles after we.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (due_q.size() != 0 && due_q[0] == cyc) begin
                chk("wdata", 64'(vram_write_data), 64'(dat_q[0]));
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end
            if (vram_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", 64'(vram_addr), 64'h7_FFFF_FFFF);
                end else begin
                    chk("waddr", 64'(vram_addr), 64'(exp_q[0][54:36]));
                    dat_q.push_back(exp_q[0][35:0]);
                    due_q.push_back(cyc + D);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_hcount = '0; pix_vcount = '0; wr_slot = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we", 64'(vram_we), 64'd0);
        chk("rst_addr", 64'(vram_addr), 64'd0);
        chk("rst_data", 64'(vram_write_data), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_perr", 64'(pair_err), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single pair with an open slot: exact latency and address.
        wr_slot = 1'b1;
        pix(10, 3, 18'h00AAA);
        exp_q.push_back({19'h00605, 18'h00AAA, 18'h15555});
        pix(11, 3, 18'h15555);
        chk("lat_count_t1", 64'(fifo_count), 64'd1);
        chk("lat_we_t1", 64'(vram_we), 64'd0);
        @(negedge clk);
        chk("lat_we_t2", 64'(vram_we), 64'd1);
        chk("lat_addr_t2", 64'(vram_addr), 64'h00605);
        chk("lat_count_t2", 64'(fifo_count), 64'd0);
        @(negedge clk);
        chk("lat_we_t3", 64'(vram_we), 64'd0);
        chk("lat_data_early", 64'(vram_write_data), 64'd0);
        @(negedge clk);
        chk("lat_data_on_time", 64'(vram_write_data), 64'({18'h00AAA, 18'h15555}));
        drain();

        // Fill with no slots, then overflow one word, then drain in order.
        wr_slot = 1'b0;
        fill4(0, 0);
        chk("fill_count", 64'(fifo_count), 64'd4);
        chk("fill_ovf", 64'(overflow), 64'd0);
        pix(8, 0, 18'd8);
        pix(9, 0, 18'd9);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(fifo_count), 64'd4);
        wr_slot = 1'b1;
        drain();
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Pairing errors: odd first, even twice, then the matching odd.
        chk("perr_before", 64'(pair_err), 64'd0);
        pix(5, 1, 18'h3);
        chk("perr_oddfirst", 64'(pair_err), 64'd1);
        pix(6, 1, 18'h0A);
        pix(6, 1, 18'h0B);
        chk("perr_nopush", 64'(fifo_count), 64'd0);
        expect_word(1, 6, 18'h0B, 18'h0C);
        pix(7, 1, 18'h0C);
        drain();

        // Out-of-window pixels are invisible to the pairing FSM.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wr_slot = 1'b0;
        chk("rst2_perr", 64'(pair_err), 64'd0);
        chk("rst2_ovf", 64'(overflow), 64'd0);
        pix(1030, 0, 18'h1);
        pix(4, 770, 18'h2);
        chk("ign_perr", 64'(pair_err), 64'd0);
        chk("ign_count", 64'(fifo_count), 64'd0);
        pix(2, 5, 18'h2_1234);
        pix(1024, 5, 18'h5);
        pix(1031, 5, 18'h6);
        pix(6, 768, 18'h7);
        expect_word(5, 2, 18'h2_1234, 18'h1_0F0F);
        pix(3, 5, 18'h1_0F0F);
        chk("edge_perr", 64'(pair_err), 64'd0);
        chk("edge_count", 64'(fifo_count), 64'd1);
        wr_slot = 1'b1;
        drain();

        // Full FIFO with simultaneous push and pop.
        wr_slot = 1'b0;
        fill4(2, 18'h100);
        pix(8, 2, 18'h108);
        expect_word(2, 8, 18'h108, 18'h109);
        wr_slot = 1'b1;
        pix(9, 2, 18'h109);
        wr_slot = 1'b0;
        chk("pp_count", 64'(fifo_count), 64'd4);
        chk("pp_ovf", 64'(overflow), 64'd0);
        wr_slot = 1'b1;
        drain();
        repeat (4) @(negedge clk);

        // Reset while words are buffered and a write is in flight.
        wr_slot = 1'b0;
        pix(1, 0, 18'h1);
        chk("mid_perr_set", 64'(pair_err), 64'd1);
        fill4(4, 18'h200);
        wr_slot = 1'b1;
        @(negedge clk);
        wr_slot = 1'b0;
        chk("mid_we", 64'(vram_we), 64'd1);
        chk("mid_count", 64'(fifo_count), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        dat_q.delete();
        due_q.delete();
        chk("mrst_we", 64'(vram_we), 64'd0);
        chk("mrst_count", 64'(fifo_count), 64'd0);
        chk("mrst_perr", 64'(pair_err), 64'd0);
        chk("mrst_ovf", 64'(overflow), 64'd0);
        chk("mrst_data", 64'(vram_write_data), 64'd0);
        reset = 1'b0;
        wr_slot = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_data", 64'(vram_write_data), 64'd0);
        chk("post_rst_count", 64'(fifo_count), 64'd0);

        chk("final_pending", 64'(exp_q.size() + dat_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
